// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out stage feeding a WIDTH-deep SIPO.
// Takes one WIDTH-bit word per valid/ready handshake and shifts it out LSB
// first on sd, one bit per clock, with sd_valid marking data cycles.
// Build option: define PARITY_EN to add an even-parity cycle after each word
// (adds the par_valid output port and a PARITY state).
module piso_serializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sd,
    output logic             sd_valid,
    output logic             busy,
    output logic             done,
`ifdef PARITY_EN
    output logic             par_valid,
`endif
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH + 1);

    // Handshake: a word is accepted on a rising edge where din_valid and
    // din_ready are both high. din_ready depends only on registered state,
    // never on din_valid. A producer that raises din_valid must hold din and
    // din_valid steady until the accept edge; din is ignored at other times.

`ifdef PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;
`endif

    state_t          state;
    state_t          state_n;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]   cnt;
    logic            last_bit;
    logic            accept;
`ifdef PARITY_EN
    logic            par_bit;
`endif

    assign last_bit = (state == SHIFT) && (cnt == CW'(WIDTH - 1));

`ifdef PARITY_EN
    // With parity, the next word may only start after the parity cycle.
    assign din_ready = (state == IDLE) || (state == PARITY);
`else
    // Without parity, accepting on the last data bit gives zero-bubble words.
    assign din_ready = (state == IDLE) || last_bit;
`endif

    assign accept    = din_valid && din_ready;
    assign sd_valid  = (state == SHIFT);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

`ifdef PARITY_EN
    assign par_valid = (state == PARITY);
    // sd comes from registers only: the shift LSB, or the latched parity bit.
    assign sd        = (state == PARITY) ? par_bit : shreg[0];
`else
    // sd comes straight from the shift register LSB.
    assign sd        = shreg[0];
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic: reload on accept, leave SHIFT after the last bit.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
`ifdef PARITY_EN
                    state_n = PARITY;
`else
                    state_n = accept ? SHIFT : IDLE;
`endif
                end
            end
`ifdef PARITY_EN
            PARITY: begin
                state_n = accept ? SHIFT : IDLE;
            end
`endif
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Datapath: load on accept, otherwise shift right while in SHIFT.
    // cnt returns to 0 after the last bit so it never leaves 0..WIDTH-1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (accept) begin
            shreg <= din;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            shreg <= shreg >> 1;
            cnt   <= last_bit ? '0 : cnt + CW'(1);
        end
    end

    // done: one cycle after the last data bit, when the SIPO holds the word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done <= 1'b0;
        end else begin
            done <= last_bit;
        end
    end

`ifdef PARITY_EN
    // Even parity of the accepted word, held for the parity cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_bit <= 1'b0;
        end else if (accept) begin
            par_bit <= ^din;
        end
    end
`endif

endmodule
